// File: rtl/sparse_mac_accumulator.sv
// -----------------------------------------------------------------------------
// sparse_mac_accumulator
//
// Purpose:
//   Consumes the match stream of the sparse priority encoder. For each matched
//   bit position it finds the IFM and filter operands inside their compressed
//   (zero-skipped) data vectors, using a prefix popcount of each mask. It
//   multiplies the operands and accumulates the products. When the encoder
//   flags the end of a group, the block emits one dot-product result and clears
//   its accumulator for the next group.
//
//   Pipeline:
//     stage 1 - prefix popcount and operand select, registered
//     stage 2 - multiply-accumulate, with result capture on last
//   A match presented with last_i in cycle T gives result_valid_o in cycle T+2.
//
// Configuration macro:
//   SPARSE_MAC_SAT_EN - when defined, the accumulator saturates to the signed
//                       ACC_W range. When undefined, it wraps modulo 2^ACC_W.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous, active-high reset
//   valid_i        match_addr_i is a real match this cycle
//   match_addr_i   matched bit position
//   last_i         this cycle ends the current group
//   ifm_mask_i     IFM non-zero bitmap
//   filter_mask_i  filter non-zero bitmap
//   ifm_data_i     compressed IFM values, element k at [k*DATA_W +: DATA_W]
//   filter_data_i  compressed filter values, same packing
//   result_o       signed dot product of the finished group
//   result_count_o number of products in the finished group
//   result_valid_o one-cycle pulse qualifying result_o / result_count_o
// -----------------------------------------------------------------------------
module sparse_mac_accumulator #(
    parameter int SIZE   = 128,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    input  logic [$clog2(SIZE)-1:0]    match_addr_i,
    input  logic                       last_i,
    input  logic [SIZE-1:0]            ifm_mask_i,
    input  logic [SIZE-1:0]            filter_mask_i,
    input  logic [SIZE*DATA_W-1:0]     ifm_data_i,
    input  logic [SIZE*DATA_W-1:0]     filter_data_i,
    output logic signed [ACC_W-1:0]    result_o,
    output logic [$clog2(SIZE):0]      result_count_o,
    output logic                       result_valid_o
);

    localparam int AW    = $clog2(SIZE);
    localparam int CNT_W = AW + 1;

    // ------------------------------------------------------------------
    // Stage 1: prefix popcount and operand select
    // ------------------------------------------------------------------
    logic [SIZE-1:0]          below_mask;   // bits strictly below match_addr_i
    logic signed [DATA_W-1:0] ifm_elem    [SIZE];
    logic signed [DATA_W-1:0] filter_elem [SIZE];

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
        assign below_mask[gi]  = (gi < int'(match_addr_i));
        assign ifm_elem[gi]    = ifm_data_i[gi*DATA_W +: DATA_W];
        assign filter_elem[gi] = filter_data_i[gi*DATA_W +: DATA_W];
    end

    // The masked vector never has more than match_addr_i bits set, so the
    // count always fits in AW bits.
    function automatic logic [AW-1:0] popcount(input logic [SIZE-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < SIZE; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c[AW-1:0];
    endfunction

    logic [AW-1:0] ifm_idx;
    logic [AW-1:0] filter_idx;

    assign ifm_idx    = popcount(ifm_mask_i & below_mask);
    assign filter_idx = popcount(filter_mask_i & below_mask);

    logic signed [DATA_W-1:0] op_a_q, op_a_d;
    logic signed [DATA_W-1:0] op_b_q, op_b_d;
    logic                     s1_valid_q, s1_valid_d;
    logic                     s1_last_q, s1_last_d;

    always_comb begin
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        s1_valid_d = valid_i;
        s1_last_d  = last_i;
        // Operands are only sampled on real matches. Empty-group and bubble
        // cycles leave them untouched.
        if (valid_i) begin
            op_a_d = ifm_elem[ifm_idx];
            op_b_d = filter_elem[filter_idx];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: multiply-accumulate
    // ------------------------------------------------------------------
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    addend;
    logic signed [ACC_W-1:0]    sum;
    logic [CNT_W-1:0]           cnt_sum;

    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [ACC_W-1:0]    result_q, result_d;
    logic [CNT_W-1:0]           result_count_q, result_count_d;
    logic                       result_valid_q, result_valid_d;

    assign prod    = op_a_q * op_b_q;
    // The size cast keeps the signedness of prod, so the value is sign-extended.
    assign addend  = s1_valid_q ? ACC_W'(prod) : '0;
    assign cnt_sum = cnt_q + CNT_W'(s1_valid_q);

`ifdef SPARSE_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // One guard bit is enough: the two top bits disagree only when the
    // addition left the ACC_W range.
    logic [ACC_W:0] wide_sum;
    assign wide_sum = {acc_q[ACC_W-1], acc_q} + {addend[ACC_W-1], addend};

    always_comb begin
        sum = wide_sum[ACC_W-1:0];
        if (wide_sum[ACC_W] != wide_sum[ACC_W-1]) begin
            sum = wide_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    assign sum = acc_q + addend;
`endif

    always_comb begin
        acc_d          = sum;
        cnt_d          = cnt_sum;
        result_d       = result_q;
        result_count_d = result_count_q;
        result_valid_d = 1'b0;
        if (s1_last_q) begin
            result_d       = sum;
            result_count_d = cnt_sum;
            result_valid_d = 1'b1;
            acc_d          = '0;
            cnt_d          = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_a_q         <= '0;
            op_b_q         <= '0;
            s1_valid_q     <= 1'b0;
            s1_last_q      <= 1'b0;
            acc_q          <= '0;
            cnt_q          <= '0;
            result_q       <= '0;
            result_count_q <= '0;
            result_valid_q <= 1'b0;
        end else begin
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            s1_valid_q     <= s1_valid_d;
            s1_last_q      <= s1_last_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_count_q <= result_count_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign result_o       = result_q;
    assign result_count_o = result_count_q;
    assign result_valid_o = result_valid_q;

endmodule
